// File: rtl/jseq_pkg.sv
// Shared types for the jsequencer: the four CPU clock phases and their clock decode.
package jseq_pkg;

  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2,
    P3 = 2'd3
  } phase_e;

  // Returns {wclk, wclkd}; wclkd is wclk delayed by one phase.
  function automatic logic [1:0] phase_clocks(input phase_e ph);
    logic [1:0] clks;
    clks = 2'b00;
    unique case (ph)
      P0: clks = 2'b00;
      P1: clks = 2'b10;
      P2: clks = 2'b11;
      P3: clks = 2'b01;
    endcase
    return clks;
  endfunction

endpackage

// File: rtl/jsequencer_if.sv
// Control-side bundle of the jsequencer: run/step/early-end requests in, clock phases and stepper out.
interface jsequencer_if #(
  parameter int NSTEPS = 6,
  parameter int CW     = 16
);

  logic                run;
  logic                step_req;
  logic                early_end;
  logic                wclk;
  logic                wclkd;
  logic                wclke;
  logic                wclks;
  logic [0:NSTEPS-1]   bos;
  logic                halted;
  logic                inst_done;
  logic [CW-1:0]       cyc_count;

  modport master (
    output run, step_req, early_end,
    input  wclk, wclkd, wclke, wclks, bos, halted, inst_done, cyc_count
  );

  modport slave (
    input  run, step_req, early_end,
    output wclk, wclkd, wclke, wclks, bos, halted, inst_done, cyc_count
  );

endinterface

// File: rtl/jphase_gen.sv
// Phase generator: DIV-cycle divider, P0..P3 phase FSM and run/single-step gating.
// Strobes cyc_end on the clk tick that takes P3 back to P0.
module jphase_gen
  import jseq_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   run,
  input  logic   step_req,
  output phase_e phase,
  output logic   cyc_end,
  output logic   halted
);

  localparam int             DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(DIV - 1);

  phase_e         phase_q, phase_d;
  logic [DW-1:0]  div_q, div_d;
  logic           pend_q, pend_d;
  logic           tick_last;

  assign tick_last = (div_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= P0;
      div_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
    end
  end

  // A stalled P0 keeps div at DIV-1 so the restart goes straight to P1.
  always_comb begin
    phase_d = phase_q;
    div_d   = div_q;
    pend_d  = pend_q;
    if (tick_last) begin
      unique case (phase_q)
        P0: begin
          if (run || pend_q) begin
            phase_d = P1;
            div_d   = '0;
            pend_d  = 1'b0;
          end
        end
        P1: begin
          phase_d = P2;
          div_d   = '0;
        end
        P2: begin
          phase_d = P3;
          div_d   = '0;
        end
        P3: begin
          phase_d = P0;
          div_d   = '0;
        end
      endcase
    end else begin
      div_d = div_q + 1'b1;
    end
    if (halted && step_req) begin
      pend_d = 1'b1;
    end
  end

  always_comb begin
    phase   = phase_q;
    halted  = (phase_q == P0) && !run && !pend_q;
    cyc_end = (phase_q == P3) && tick_last;
  end

endmodule

// File: rtl/jsequencer.sv
// CPU clock-phase and one-hot stepper sequencer with run/halt, single-step,
// early end-of-instruction and a completed-instruction counter.
module jsequencer
  import jseq_pkg::*;
#(
  parameter int NSTEPS = 6,
  parameter int DIV    = 1,
  parameter int CW     = 16
) (
  input  logic         clk,
  input  logic         reset,
  jsequencer_if.slave  bus
);

  localparam int             SW        = $clog2(NSTEPS);
  localparam logic [SW-1:0]  STEP_LAST = SW'(NSTEPS - 1);

  phase_e         phase;
  logic           cyc_end;
  logic           halted;
  logic [1:0]     clks;

  logic [SW-1:0]  step_q, step_d;
  logic [CW-1:0]  cyc_count_q, cyc_count_d;
  logic           inst_done_q, inst_done_d;

  jphase_gen #(
    .DIV (DIV)
  ) u_phase_gen (
    .clk      (clk),
    .reset    (reset),
    .run      (bus.run),
    .step_req (bus.step_req),
    .phase    (phase),
    .cyc_end  (cyc_end),
    .halted   (halted)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q      <= '0;
      cyc_count_q <= '0;
      inst_done_q <= 1'b0;
    end else begin
      step_q      <= step_d;
      cyc_count_q <= cyc_count_d;
      inst_done_q <= inst_done_d;
    end
  end

  // early_end only matters on the P3->P0 tick; on the last step it still wraps once.
  always_comb begin
    step_d      = step_q;
    cyc_count_d = cyc_count_q;
    inst_done_d = 1'b0;
    if (cyc_end) begin
      if (bus.early_end || (step_q == STEP_LAST)) begin
        step_d      = '0;
        cyc_count_d = cyc_count_q + 1'b1;
        inst_done_d = 1'b1;
      end else begin
        step_d = step_q + 1'b1;
      end
    end
  end

  assign clks          = phase_clocks(phase);
  assign bus.wclk      = clks[1];
  assign bus.wclkd     = clks[0];
  assign bus.wclke     = clks[1] | clks[0];
  assign bus.wclks     = clks[1] & clks[0];
  assign bus.halted    = halted;
  assign bus.inst_done = inst_done_q;
  assign bus.cyc_count = cyc_count_q;

  for (genvar i = 0; i < NSTEPS; i++) begin : g_bos
    assign bus.bos[i] = (step_q == SW'(i));
  end

endmodule
